seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial bit-sequence detector; the successor to the team's fixed 3-bit "0-1-0" detector FSM.
- Pattern is run-time programmable, and its length is set by a parameter.
- Adds an input-valid qualifier, an overlap/non-overlap mode, a synchronous clear and a saturating match counter.
- Sits on a serial data path; its match pulse feeds downstream control logic.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..16).
- CNT_W, 8, width of the saturating match counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Clear  input  1  synchronous clear of history, counter and output. Priority over In_Valid.
- In_Valid  input  1  qualifies Input; the bit is accepted on a rising edge with In_Valid=1.
- Input  input  1  serial data bit.
- Pattern  input  PAT_W  target sequence. Pattern[PAT_W-1] is the first bit received, Pattern[0] the last.
- Overlap  input  1  1 = overlapping matches allowed; 0 = history flushed after each match.
- Output  output  1  registered match pulse.
- Match_Count  output  CNT_W  number of matches, saturating.
- Fill  output  clog2(PAT_W+1)  valid history bits held, 0..PAT_W.
- Current_State  output  2  state encoding, see Behaviour.

Behaviour:
- Reset (async): hist=0, Fill=0, Match_Count=0, Output=0, Current_State=S_IDLE. Takes effect immediately, without waiting for CLK. Any partial sequence is discarded.
- Clear=1 at an edge: same values as Reset, applied at that edge. The Input bit is ignored even if In_Valid=1.
- Accepted bit, computed at the edge:
  - hist_n = {hist[PAT_W-2:0], Input}
  - fill_n = min(Fill+1, PAT_W)
  - hit = (fill_n==PAT_W) && (hist_n==Pattern)
- On hit:
  - Output=1 for exactly one cycle, the cycle after the accepting edge (latency 1).
  - Match_Count increments, holding at 2^CNT_W-1.
  - Overlap=1: Fill stays PAT_W and hist=hist_n.
  - Overlap=0: Fill=0 and hist=0.
- No accepted bit (In_Valid=0): hist, Fill and Match_Count hold; Output=0.
  - A pulse is never stretched by In_Valid gaps.
- Back-to-back hits (overlap mode, In_Valid every cycle) give Output high on consecutive cycles. Each hit counts once.
- State encoding, registered:
  - S_IDLE=0: Fill==0, no hit.
  - S_FILL=1: 0<Fill<PAT_W.
  - S_ARMED=2: Fill==PAT_W, no hit.
  - S_HIT=3: previous edge produced a hit. Output=1 exactly when in S_HIT.
- Transitions on an accepted bit:
  - IDLE→FILL.
  - FILL→FILL, or →ARMED when fill_n==PAT_W and no hit, or →HIT on a hit.
  - ARMED→ARMED or HIT.
  - HIT→HIT or ARMED when Overlap=1.
  - HIT→FILL when Overlap=0: fill_n counts from 0, so Fill becomes 1 after the accepted bit.
- Transitions with no accepted bit:
  - HIT→IDLE when Overlap=0.
  - HIT→ARMED when Overlap=1.
  - All other states hold.
- Pattern and Overlap are sampled combinationally every edge; changing them does not flush history.
- No X propagation: every register has a reset value, and the next-state logic has a default branch →S_IDLE.

Decomposition:
- Package seq_det_pkg holds S_IDLE/S_FILL/S_ARMED/S_HIT localparams and the STATE_W=2 constant.
- Sub-module sat_counter (parameter W): inc, clr, count. Used for Match_Count.
- History shift register, fill tracking and state logic stay in seq_detector_param.

Test Plan:
- PAT_W=3, Pattern=3'b010, Overlap=0; stream 0,1,0 with In_Valid=1 → Output=1 one cycle after the third edge; Match_Count=1; then state S_IDLE, Fill=0.
- PAT_W=3, Pattern=3'b101; stream 1,0,1,0,1. Overlap=1 → hits after bits 3 and 5, Match_Count=2. Overlap=0 → hit after bit 3 only, Match_Count=1.
- Same as the first scenario with In_Valid=0 for 2 cycles between every bit → one Output pulse exactly 1 cycle wide; Fill holds during gaps.
- PAT_W=4, CNT_W=2, Pattern=4'b1111, Overlap=1; ten 1s → Output high for 7 consecutive cycles; Match_Count saturates at 3.
- Pattern=3'b010: send 0,1, assert Clear with In_Valid=1 and Input=0 → Fill=0, no hit; then 0,1,0 → exactly one hit.
- Assert Reset asynchronously between edges while in S_HIT → Output, Match_Count and Fill read 0 before the next CLK edge.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared definitions for the parametrised sequence detector.
//   STATE_W  width of the Current_State encoding
//   state_e  S_IDLE=0, S_FILL=1, S_ARMED=2, S_HIT=3
package seq_det_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ARMED = 2'd2,
        S_HIT   = 2'd3
    } state_e;

endpackage

// File: rtl/seq_detector_param_if.sv
// seq_detector_param_if: groups the detector's control, serial data and status signals.
//   master modport: drives Clear/In_Valid/Input/Pattern/Overlap, observes status.
//   slave modport : the detector side.
//   Status: Output (match pulse), Match_Count, Fill, Current_State.
interface seq_detector_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    import seq_det_pkg::*;

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    logic               Clear;
    logic               In_Valid;
    logic               Input;
    logic [PAT_W-1:0]   Pattern;
    logic               Overlap;
    logic               Output;
    logic [CNT_W-1:0]   Match_Count;
    logic [FILL_W-1:0]  Fill;
    logic [STATE_W-1:0] Current_State;

    modport master (
        output Clear, In_Valid, Input, Pattern, Overlap,
        input  Output, Match_Count, Fill, Current_State
    );

    modport slave (
        input  Clear, In_Valid, Input, Pattern, Overlap,
        output Output, Match_Count, Fill, Current_State
    );

endinterface

// File: rtl/seq_detector_param_sat_counter.sv
// sat_counter: W-bit up counter that holds at all-ones.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one event this edge
//   clr      : synchronous clear, wins over inc
//   count    : current value
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial pattern detector.
//   CLK, Reset : clock, asynchronous active-high reset
//   bus (slave): Clear, In_Valid, Input, Pattern, Overlap in;
//                Output (1-cycle match pulse), Match_Count, Fill, Current_State out.
// Pattern[PAT_W-1] is the oldest bit of the window, Pattern[0] the newest.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic               CLK,
    input logic               Reset,
    seq_detector_param_if.slave bus
);

    localparam int unsigned       FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d, hist_n;
    logic [FILL_W-1:0] fill_q, fill_d, fill_n;
    state_e            state_q, state_d;
    logic              hit;
    logic [CNT_W-1:0]  match_count;

    always_comb begin
        hist_n  = {hist_q[PAT_W-2:0], bus.Input};
        fill_n  = (fill_q >= FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
        hit     = 1'b0;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;

        if (bus.Clear) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = S_IDLE;
        end else if (bus.In_Valid) begin
            hit = (fill_n == FILL_MAX) && (hist_n == bus.Pattern);
            if (hit) begin
                state_d = S_HIT;
                if (bus.Overlap) begin
                    hist_d = hist_n;
                    fill_d = fill_n;
                end else begin
                    // Non-overlap: the matched window is consumed entirely.
                    hist_d = '0;
                    fill_d = '0;
                end
            end else begin
                hist_d  = hist_n;
                fill_d  = fill_n;
                state_d = (fill_n == FILL_MAX) ? S_ARMED : S_FILL;
            end
        end else begin
            // Idle edge: only the hit pulse decays, everything else holds.
            case (state_q)
                S_HIT:                  state_d = bus.Overlap ? S_ARMED : S_IDLE;
                S_IDLE, S_FILL, S_ARMED: state_d = state_q;
                default:                state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= S_IDLE;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (CLK),
        .rst  (Reset),
        .inc  (hit),
        .clr  (bus.Clear),
        .count(match_count)
    );

    assign bus.Output        = (state_q == S_HIT);
    assign bus.Match_Count   = match_count;
    assign bus.Fill          = fill_q;
    assign bus.Current_State = state_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: two instances (PAT_W=3/CNT_W=8 and PAT_W=4/CNT_W=2)
// driven with the same serial stream, each with its own pattern.
module tb_seq_detector_param;
    import seq_det_pkg::*;

    logic CLK = 1'b0;
    logic Reset;
    always #5 CLK = ~CLK;

    seq_detector_param_if #(.PAT_W(3), .CNT_W(8)) bus3 ();
    seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus4 ();

    seq_detector_param #(.PAT_W(3), .CNT_W(8)) dut3 (.CLK(CLK), .Reset(Reset), .bus(bus3));
    seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut4 (.CLK(CLK), .Reset(Reset), .bus(bus4));

    typedef struct {
        int unsigned out;
        int unsigned cnt;
        int unsigned fill;
        int unsigned st;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;
    int p4       = 0;

    // Reference model: window value kept as an integer modulo 2^W plus a bit count.
    int unsigned m_val[2];
    int unsigned m_fill[2];
    int unsigned m_cnt[2];
    int unsigned m_st[2];
    bit          m_hit[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_val[i] = 0; m_fill[i] = 0; m_cnt[i] = 0; m_st[i] = 0; m_hit[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input int unsigned pat, input bit clr, input bit v,
                              input bit b, input bit ov);
        int unsigned w;
        int unsigned cmax;
        exp_t        e;
        w    = (i == 0) ? 3 : 4;
        cmax = (i == 0) ? 255 : 3;
        if (clr) begin
            m_val[i] = 0; m_fill[i] = 0; m_cnt[i] = 0; m_hit[i] = 0; m_st[i] = 0;
        end else if (v) begin
            m_val[i] = ((m_val[i] * 2) + (b ? 1 : 0)) % (1 << w);
            if (m_fill[i] < w) m_fill[i]++;
            m_hit[i] = (m_fill[i] == w) && (m_val[i] == pat);
            if (m_hit[i]) begin
                if (m_cnt[i] < cmax) m_cnt[i]++;
                m_st[i] = 3;
                if (!ov) begin
                    m_val[i]  = 0;
                    m_fill[i] = 0;
                end
            end else begin
                m_st[i] = (m_fill[i] == w) ? 2 : 1;
            end
        end else begin
            if (m_hit[i]) m_st[i] = ov ? 2 : 0;
            m_hit[i] = 0;
        end
        e.out  = m_hit[i] ? 1 : 0;
        e.cnt  = m_cnt[i];
        e.fill = m_fill[i];
        e.st   = m_st[i];
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Called just after a falling edge: apply inputs, predict the next rising edge.
    task automatic drive(input bit clr, input bit v, input bit b, input bit ov);
        bus3.Clear = clr; bus3.In_Valid = v; bus3.Input = b; bus3.Overlap = ov;
        bus4.Clear = clr; bus4.In_Valid = v; bus4.Input = b; bus4.Overlap = ov;
        model_step(0, 32'(bus3.Pattern), clr, v, b, ov);
        model_step(1, 32'(bus4.Pattern), clr, v, b, ov);
        @(negedge CLK);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input int gap, input bit ov);
        for (int k = n - 1; k >= 0; k--) begin
            drive(1'b0, 1'b1, bits[k], ov);
            for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 1'b0, ov);
        end
    endtask

    // Monitor: compares every registered output against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("d3.Output", 32'(bus3.Output), e.out);
                check("d3.Match_Count", 32'(bus3.Match_Count), e.cnt);
                check("d3.Fill", 32'(bus3.Fill), e.fill);
                check("d3.Current_State", 32'(bus3.Current_State), e.st);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("d4.Output", 32'(bus4.Output), e.out);
                check("d4.Match_Count", 32'(bus4.Match_Count), e.cnt);
                check("d4.Fill", 32'(bus4.Fill), e.fill);
                check("d4.Current_State", 32'(bus4.Current_State), e.st);
                if (bus4.Output === 1'b1) p4++;
            end
        end
    end

    initial begin
        bit ov_r;
        bit clr_r;
        bit v_r;
        bit b_r;

        Reset = 1'b1;
        bus3.Clear = 0; bus3.In_Valid = 0; bus3.Input = 0; bus3.Overlap = 0; bus3.Pattern = '0;
        bus4.Clear = 0; bus4.In_Valid = 0; bus4.Input = 0; bus4.Overlap = 0; bus4.Pattern = '0;
        model_reset();
        #2;
        check("rst d3.Output", 32'(bus3.Output), 0);
        check("rst d3.Match_Count", 32'(bus3.Match_Count), 0);
        check("rst d3.Fill", 32'(bus3.Fill), 0);
        check("rst d3.Current_State", 32'(bus3.Current_State), 0);
        check("rst d4.Output", 32'(bus4.Output), 0);
        check("rst d4.Match_Count", 32'(bus4.Match_Count), 0);
        check("rst d4.Fill", 32'(bus4.Fill), 0);
        check("rst d4.Current_State", 32'(bus4.Current_State), 0);
        @(negedge CLK);
        Reset = 1'b0;
        @(negedge CLK);

        // 0,1,0 with non-overlap on the 3-bit detector.
        bus3.Pattern = 3'b010;
        bus4.Pattern = 4'b1111;
        send_bits(16'b010, 3, 0, 1'b0);
        check("s1 pulse", 32'(bus3.Output), 1);
        check("s1 count", 32'(bus3.Match_Count), 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("s1 idle state", 32'(bus3.Current_State), 0);
        check("s1 idle fill", 32'(bus3.Fill), 0);

        // 1,0,1,0,1 with and without overlap.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        bus3.Pattern = 3'b101;
        send_bits(16'b10101, 5, 0, 1'b1);
        check("s2 overlap count", 32'(bus3.Match_Count), 2);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b10101, 5, 0, 1'b0);
        check("s2 non-overlap count", 32'(bus3.Match_Count), 1);

        // Same stream with two idle cycles between bits.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        bus3.Pattern = 3'b010;
        send_bits(16'b010, 3, 2, 1'b0);
        check("s3 gapped count", 32'(bus3.Match_Count), 1);

        // Ten 1s into the 4-bit all-ones detector: 7 back-to-back hits, count saturates.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        p4 = 0;
        send_bits(16'h03ff, 10, 0, 1'b1);
        check("s4 pulse cycles", 32'(p4), 7);
        check("s4 saturated count", 32'(bus4.Match_Count), 3);

        // Clear mid-sequence discards the partial match and the qualified bit.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b01, 2, 0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        check("s5 fill after clear", 32'(bus3.Fill), 0);
        send_bits(16'b010, 3, 0, 1'b0);
        check("s5 count", 32'(bus3.Match_Count), 1);

        // Asynchronous reset while in S_HIT, between clock edges.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        send_bits(16'b010, 3, 0, 1'b0);
        check("s6 in hit", 32'(bus3.Current_State), 3);
        bus3.In_Valid = 1'b0;
        bus4.In_Valid = 1'b0;
        Reset = 1'b1;
        #1;
        check("s6 async Output", 32'(bus3.Output), 0);
        check("s6 async Match_Count", 32'(bus3.Match_Count), 0);
        check("s6 async Fill", 32'(bus3.Fill), 0);
        check("s6 async State", 32'(bus3.Current_State), 0);
        check("s6 async d4 Fill", 32'(bus4.Fill), 0);
        model_reset();
        #1;
        Reset = 1'b0;
        @(negedge CLK);

        // Randomised traffic with occasional clears, mode and pattern changes.
        ov_r = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) ov_r = ~ov_r;
            if ($urandom_range(0, 29) == 0) begin
                bus3.Pattern = 3'($urandom_range(0, 7));
                bus4.Pattern = 4'($urandom_range(0, 15));
            end
            clr_r = ($urandom_range(0, 99) < 3);
            v_r   = ($urandom_range(0, 99) < 70);
            b_r   = 1'($urandom_range(0, 1));
            drive(clr_r, v_r, b_r, ov_r);
        end
        drive(1'b0, 1'b0, 1'b0, ov_r);
        drive(1'b0, 1'b0, 1'b0, ov_r);
        check("scoreboard drained", 32'(q0.size() + q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
